// File: rtl/mpsoc_msi_wb_cdc_pkg.sv
// Shared types for the Wishbone CDC toggle-handshake endpoints (tx and rx).
package mpsoc_msi_wb_cdc_pkg;

  // Handshake endpoint state: idle, or one word outstanding on the bus.
  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_BUSY = 1'b1
  } hs_state_t;

endpackage

// File: rtl/mpsoc_msi_wb_sync2.sv
// Two-flop synchroniser for a single asynchronous level/toggle signal.
module mpsoc_msi_wb_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // First flop may go metastable; second flop gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/mpsoc_msi_wb_cdc_hs_tx.sv
// Source end of the toggle-handshake CDC: a small FIFO feeding a held data
// bus, one req toggle per word, next word released on the synced ack toggle.
module mpsoc_msi_wb_cdc_hs_tx
  import mpsoc_msi_wb_cdc_pkg::*;
#(
  parameter int  DW    = 32,
  parameter int  DEPTH = 4,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [DW-1:0] data_o,
  output logic          req_o,
  input  logic          ack_i,
  output logic          busy_o,
  output logic [LW-1:0] level_o,
  output logic          err_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;
  logic [LW-1:0] count_next;
  hs_state_t     state_reg;
  hs_state_t     state_next;
  logic          pop_pend_reg;   // head word sits in rd_data_reg, bus load next edge
  logic [DW-1:0] rd_data_reg;
  logic [DW-1:0] data_reg;
  logic          req_reg;
  logic          err_reg;

  logic ack_s;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic ack_done;

  mpsoc_msi_wb_sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_i),
    .q     (ack_s)
  );

  assign full     = (count_reg == LW'(DEPTH));
  assign empty    = (count_reg == '0);
  // No bypass: a full FIFO refuses the push even if a pop happens this cycle.
  assign push     = s_valid_i & ~full;
  assign ack_done = (ack_s == req_reg);
  // Start from IDLE regardless of ack; in BUSY only once the current word is acked.
  // pop_pend_reg blocks a second pop before the first word reaches the bus.
  assign pop      = ~empty & ~pop_pend_reg & ((state_reg == HS_IDLE) | ack_done);

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + LW'(1);
      2'b01:   count_next = count_reg - LW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Handshake FSM: BUSY on every bus load, IDLE once acked with nothing queued.
  always_comb begin
    state_next = state_reg;
    if (pop_pend_reg) begin
      state_next = HS_BUSY;
    end else if ((state_reg == HS_BUSY) && ack_done && empty) begin
      state_next = HS_IDLE;
    end
  end

  // FIFO storage with registered read; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data_i;
    end
    if (pop) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

  // Control state; data bus and req toggle are updated on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      state_reg    <= HS_IDLE;
      pop_pend_reg <= 1'b0;
      data_reg     <= '0;
      req_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg    <= count_next;
      state_reg    <= state_next;
      pop_pend_reg <= pop;
      if (pop_pend_reg) begin
        data_reg <= rd_data_reg;
        req_reg  <= ~req_reg;
      end
      // An ack toggle with nothing outstanding is a protocol error; sticky.
      if ((state_reg == HS_IDLE) && (ack_s != req_reg)) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign s_ready_o = ~full;
  assign data_o    = data_reg;
  assign req_o     = req_reg;
  assign busy_o    = (state_reg == HS_BUSY);
  assign level_o   = count_reg;
  assign err_o     = err_reg;

endmodule

// File: tb/tb_mpsoc_msi_wb_cdc_hs_tx.sv
// Self-checking bench for the toggle-handshake CDC transmitter.
module tb_mpsoc_msi_wb_cdc_hs_tx;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] data_o;
  logic          req_o;
  logic          ack_i;
  logic          busy_o;
  logic [LW-1:0] level_o;
  logic          err_o;

  mpsoc_msi_wb_cdc_hs_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .data_o    (data_o),
    .req_o     (req_o),
    .ack_i     (ack_i),
    .busy_o    (busy_o),
    .level_o   (level_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle vector: inputs for the cycle, expected outputs after its edge.
  typedef struct {
    logic          v;
    logic [31:0]   din;
    logic          ack;
    int            lvl;
    logic          rdy;
    logic          req;
    logic          busy;
    logic          err;
    logic [31:0]   dout;
  } vec_t;

  localparam logic [31:0] W1 = 32'hA5A5_0001;
  localparam logic [31:0] W2 = 32'h0000_0002;

  vec_t        tbl [20];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] w [6];
  logic [31:0] exp_q [$];
  logic        last_req;
  logic [31:0] last_data;
  int          n_seen, gaps, last_cyc, acts;
  logic        acc;
  int          push_cnt, rx_cnt, ack_cnt;
  logic        ack_wait;

  function automatic vec_t mk(logic v, logic [31:0] din, logic a, int lvl,
                              logic rdy, logic q, logic b, logic e, logic [31:0] dout);
    vec_t r;
    r.v = v; r.din = din; r.ack = a; r.lvl = lvl; r.rdy = rdy;
    r.req = q; r.busy = b; r.err = e; r.dout = dout;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    ack_i     = 1'b0;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single word, ack after 5 cycles with a second word queued, then a spurious ack.
    tbl[0]  = mk(1, W1, 0, 1, 1, 0, 0, 0, 32'h0);
    tbl[1]  = mk(0, 0,  0, 0, 1, 0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 0,  0, 0, 1, 1, 1, 0, W1);
    tbl[3]  = mk(0, 0,  0, 0, 1, 1, 1, 0, W1);
    tbl[4]  = mk(1, W2, 0, 1, 1, 1, 1, 0, W1);
    tbl[5]  = mk(0, 0,  0, 1, 1, 1, 1, 0, W1);
    tbl[6]  = mk(0, 0,  0, 1, 1, 1, 1, 0, W1);
    tbl[7]  = mk(0, 0,  1, 1, 1, 1, 1, 0, W1);
    tbl[8]  = mk(0, 0,  1, 1, 1, 1, 1, 0, W1);
    tbl[9]  = mk(0, 0,  1, 0, 1, 1, 1, 0, W1);
    tbl[10] = mk(0, 0,  1, 0, 1, 0, 1, 0, W2);
    tbl[11] = mk(0, 0,  1, 0, 1, 0, 1, 0, W2);
    tbl[12] = mk(0, 0,  0, 0, 1, 0, 1, 0, W2);
    tbl[13] = mk(0, 0,  0, 0, 1, 0, 1, 0, W2);
    tbl[14] = mk(0, 0,  0, 0, 1, 0, 0, 0, W2);
    tbl[15] = mk(0, 0,  1, 0, 1, 0, 0, 0, W2);
    tbl[16] = mk(0, 0,  1, 0, 1, 0, 0, 0, W2);
    tbl[17] = mk(0, 0,  1, 0, 1, 0, 0, 1, W2);
    tbl[18] = mk(0, 0,  0, 0, 1, 0, 0, 1, W2);
    tbl[19] = mk(0, 0,  0, 0, 1, 0, 0, 1, W2);
    for (int k = 0; k < 6; k++) w[k] = 32'hC0DE_0000 + k;

    // T1: reset held with valid asserted.
    rst_n = 1'b0; ack_i = 1'b0; s_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    chk("t1_req", req_o, 0);
    chk("t1_data", data_o, 0);
    chk("t1_level", level_o, 0);
    chk("t1_ready", s_ready_o, 1);
    chk("t1_err", err_o, 0);
    chk("t1_busy", busy_o, 0);
    s_valid_i = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("t1_no_push", level_o, 0);
    $display("[TB] T1 reset checked");

    // T2/T5 table.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      s_valid_i = tbl[i].v;
      s_data_i  = tbl[i].din;
      ack_i     = tbl[i].ack;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_level", i), level_o, tbl[i].lvl);
      chk($sformatf("vec%0d_ready", i), s_ready_o, tbl[i].rdy);
      chk($sformatf("vec%0d_req", i), req_o, tbl[i].req);
      chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].busy);
      chk($sformatf("vec%0d_err", i), err_o, tbl[i].err);
      chk($sformatf("vec%0d_data", i), data_o, tbl[i].dout);
      $display("[TB] vec%0d v=%0b ack=%0b req=%0b busy=%0b lvl=%0d err=%0b data=%h",
               i, tbl[i].v, tbl[i].ack, req_o, busy_o, level_o, err_o, data_o);
    end

    // T5 follow-up: after the error a normal transfer still completes.
    s_valid_i = 1'b1; s_data_i = 32'h5A5A_0003;
    @(negedge clk);
    s_valid_i = 1'b0;
    last_req = req_o; n_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_o !== last_req) begin
        chk("t5_data", data_o, 32'h5A5A_0003);
        last_req = req_o; n_seen++;
        $display("[TB] T5 word %h after error", data_o);
      end
      ack_i = req_o;
      @(negedge clk);
    end
    chk("t5_words", n_seen, 1);
    chk("t5_busy_done", busy_o, 0);
    chk("t5_err_sticky", err_o, 1);

    // T3: six words with ack withheld.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      s_valid_i = 1'b1; s_data_i = w[k];
      chk($sformatf("t3_ready%0d", k), s_ready_o, 1);
      @(negedge clk);
    end
    s_data_i = w[5];
    for (int c = 0; c < 6; c++) begin
      chk("t3_level", level_o, 4);
      chk("t3_ready_low", s_ready_o, 0);
      chk("t3_data_w0", data_o, w[0]);
      chk("t3_busy", busy_o, 1);
      @(negedge clk);
    end
    $display("[TB] T3 full with word0 in flight, level=%0d", level_o);

    // T4: immediate acks drain words 0..5 back to back.
    last_req = req_o; n_seen = 1; gaps = 0; acc = 1'b0; last_cyc = -1;
    for (int c = 0; c < 100 && !(n_seen == 6 && !busy_o); c++) begin
      if (req_o !== last_req) begin
        if (n_seen < 6) chk($sformatf("t4_word%0d", n_seen), data_o, w[n_seen]);
        else chk("t4_extra_toggle", n_seen, 5);
        if (last_cyc >= 0) chk("t4_spacing", c - last_cyc, 4);
        $display("[TB] T4 word%0d %h at cycle %0d", n_seen, data_o, c);
        last_cyc = c; last_req = req_o; n_seen++;
      end
      if (n_seen < 6 && !busy_o) gaps++;
      ack_i = req_o;
      if (acc) s_valid_i = 1'b0;
      acc = s_valid_i & s_ready_o;
      @(negedge clk);
    end
    chk("t4_count", n_seen, 6);
    chk("t4_busy_gap", gaps, 0);
    chk("t4_idle", busy_o, 0);

    // T6: reset two cycles after a toggle with three words queued.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      s_valid_i = 1'b1; s_data_i = w[k];
      @(negedge clk);
    end
    s_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_pre_req", req_o, 1);
    chk("t6_pre_level", level_o, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_req", req_o, 0);
    chk("t6_async_data", data_o, 0);
    chk("t6_async_level", level_o, 0);
    chk("t6_async_busy", busy_o, 0);
    chk("t6_async_ready", s_ready_o, 1);
    @(negedge clk);
    @(negedge clk);
    ack_i = 1'b0; rst_n = 1'b1;
    acts = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_o !== 1'b0 || busy_o !== 1'b0 || level_o !== '0) acts++;
    end
    chk("t6_quiet", acts, 0);
    $display("[TB] T6 reset mid-busy discarded queue");

    // Randomised traffic against a queue model with a random-latency destination.
    do_reset();
    last_req = 1'b0; last_data = '0; ack_wait = 1'b0; ack_cnt = 0;
    push_cnt = 0; rx_cnt = 0;
    for (int c = 0; c < 1500 && !(c >= 400 && exp_q.size() == 0 && !busy_o); c++) begin
      if (req_o !== last_req) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_req", 1, 0);
        end else begin
          chk("rnd_order", data_o, exp_q.pop_front());
        end
        last_req = req_o; last_data = data_o; ack_wait = 1'b1;
        ack_cnt = $urandom_range(0, 3); rx_cnt++;
        $display("[TB] rnd word %0d = %h", rx_cnt, data_o);
      end else if (busy_o) begin
        chk("rnd_data_stable", data_o, last_data);
      end
      if (ack_wait) begin
        if (ack_cnt == 0) begin ack_i = last_req; ack_wait = 1'b0; end
        else ack_cnt--;
      end
      chk("rnd_level_bound", (level_o <= LW'(DEPTH)), 1);
      chk("rnd_ready_full", s_ready_o, (level_o != LW'(DEPTH)));
      if (c < 400) begin
        s_valid_i = ($urandom_range(0, 3) != 0);
        s_data_i  = $urandom;
      end else begin
        s_valid_i = 1'b0;
      end
      if (s_valid_i && s_ready_o) begin
        exp_q.push_back(s_data_i);
        push_cnt++;
      end
      @(negedge clk);
    end
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_count", rx_cnt, push_cnt);
    chk("rnd_err", err_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
